mem_write_b: RTL and testbench
==============================

MEM_WRITE_B -- requirements
Module: mem_write_B

Interface
REQ-001 SHALL have parameter D_W, default 8, element data width in bits.
REQ-002 SHALL have parameter N, default 3, number of B-matrix BRAM banks.
REQ-003 SHALL have parameter M, default 6, matrix dimension; M*M SHALL be a multiple of N (DEPTH=(M*M)/N, ADDR_W=$clog2(DEPTH)).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin loading B.
REQ-007 SHALL have port in_data  input  D_W  streamed B element, row-major.
REQ-008 SHALL have port in_valid  input  1  in_data valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data.
REQ-010 SHALL have port wr_addr_bram  output  ADDR_W x [N-1:0] unpacked  per-bank write address.
REQ-011 SHALL have port wr_data_bram  output  D_W x [N-1:0] unpacked  per-bank write data.
REQ-012 SHALL have port wr_en_bram  output  [N-1:0]  per-bank write enable.
REQ-013 SHALL have port busy  output  1  high while in LOAD.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last element is written.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, DONE.
REQ-016 IDLE: start=1 -> LOAD, bank counter and address counter cleared to 0; otherwise stay.
REQ-017 LOAD: in_ready=1; transfer occurs when in_valid & in_ready.
REQ-018 Element k (0..M*M-1, transfer order) SHALL go to bank k mod N at address k div N.
REQ-019 On each transfer bank counter increments; at N-1 it wraps to 0 and address counter increments.
REQ-020 Write outputs SHALL be registered: transfer in cycle t -> wr_en_bram[bank]=1, that bank's addr/data valid in cycle t+1; exactly one wr_en bit high per transfer.
REQ-021 Cycles without transfer SHALL drive wr_en_bram=0; wr_addr/wr_data hold last values.
REQ-022 Transfer of element M*M-1 -> DONE next cycle; in_ready SHALL be 0 from that cycle.
REQ-023 DONE: done=1 for exactly one cycle (coincident with the final write's wr_en), then IDLE.
REQ-024 in_ready SHALL be 0 in IDLE and DONE; in_valid there is ignored.
REQ-025 start asserted in LOAD or DONE SHALL be ignored.
REQ-026 in_valid gaps of any length in LOAD SHALL only stall counters, never skip addresses.
REQ-027 busy SHALL equal (state==LOAD).

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, counters 0, wr_en_bram=0, wr_addr_bram=0, wr_data_bram=0, in_ready=0, busy=0, done=0.
REQ-029 rst mid-LOAD SHALL abort without completing pending writes and without pulsing done; rst SHALL dominate simultaneous start.

Structure
REQ-030 FSM state enum and a DEPTH/ADDR_W helper SHALL live in shared package mm_pkg; N, M, D_W remain module parameters.
REQ-031 SHALL be a single module, no sub-modules; per-bank output registers generated with a genvar loop.

Verification (N=3, M=6, D_W=8)
REQ-032 Reset then start, stream values 0..35 with in_valid held -> bank0 receives 0,3,...,33 at addrs 0..11, bank1 1,4,...,34, bank2 2,5,...,35; done pulses once, in the cycle of the final write (bank2 addr 11).
REQ-033 Same stream with in_valid toggling every other cycle -> identical bank contents; no wr_en during gaps.
REQ-034 in_valid=1 with value 0xAA in IDLE and after done -> no wr_en, in_ready=0.
REQ-035 rst asserted after 17 transfers -> next cycle all outputs 0, IDLE; fresh start reloads from bank0 addr0.
REQ-036 start pulsed again mid-LOAD (after 5 transfers) -> ignored; element 5 still written to bank2 addr1.
REQ-037 Back-to-back loads: start in cycle after done -> second load begins at bank0 addr0, done pulses again.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply B-loader: FSM states and
// bank geometry helpers.
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_depth(input int unsigned m, input int unsigned n);
    return (m * m) / n;
  endfunction

  // Address width never collapses to zero, even for a single-word bank.
  function automatic int unsigned calc_addr_w(input int unsigned m, input int unsigned n);
    int unsigned d;
    d = calc_depth(m, n);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/mem_write_b.sv
// Streams a row-major M x M B matrix into N interleaved BRAM banks:
// element k lands in bank k mod N at address k div N.
module mem_write_b
  import mm_pkg::*;
#(
  parameter  int unsigned D_W    = 8,
  parameter  int unsigned N      = 3,
  parameter  int unsigned M      = 6,
  localparam int unsigned DEPTH  = calc_depth(M, N),
  localparam int unsigned ADDR_W = calc_addr_w(M, N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [D_W-1:0]    in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_addr_bram [N-1:0],
  output logic [D_W-1:0]    wr_data_bram [N-1:0],
  output logic [N-1:0]      wr_en_bram,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       BANK_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                in_ready_q;
  logic                busy_q;
  logic                done_q;
  logic                xfer;

  assign xfer = in_valid & in_ready_q;

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          bank_d  = '0;
          addr_d  = '0;
        end
      end
      ST_LOAD: begin
        if (xfer) begin
          if (bank_q == LAST_BANK) begin
            bank_d = '0;
            addr_d = addr_q + ADDR_W'(1);
            if (addr_q == LAST_ADDR) begin
              state_d = ST_DONE;
            end
          end else begin
            bank_d = bank_q + BANK_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and status flags; flags are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      in_ready_q <= (state_d == ST_LOAD);
      busy_q     <= (state_d == ST_LOAD);
      done_q     <= (state_d == ST_DONE);
    end
  end

  // Per-bank write port registers; addr/data hold between writes
  for (genvar g = 0; g < N; g++) begin : g_bank
    logic              en_q;
    logic [ADDR_W-1:0] a_q;
    logic [D_W-1:0]    d_q;
    logic              hit;

    assign hit = xfer && (bank_q == BANK_W'(g));

    always_ff @(posedge clk) begin
      if (rst) begin
        en_q <= 1'b0;
        a_q  <= '0;
        d_q  <= '0;
      end else begin
        en_q <= hit;
        if (hit) begin
          a_q <= addr_q;
          d_q <= in_data;
        end
      end
    end

    assign wr_en_bram[g]   = en_q;
    assign wr_addr_bram[g] = a_q;
    assign wr_data_bram[g] = d_q;
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_write_b.sv
// Randomized self-checking bench for mem_write_b against a transaction-level
// model (element counter plus k mod N / k div N bank mapping).
module tb_mem_write_b;

  localparam int N      = 3;
  localparam int M      = 6;
  localparam int D_W    = 8;
  localparam int DEPTH  = (M * M) / N;
  localparam int ADDR_W = 4;
  localparam int TOTAL  = M * M;

  logic              clk = 1'b0;
  logic              rst, start, in_valid;
  logic [D_W-1:0]    in_data;
  logic              in_ready, busy, done;
  logic [ADDR_W-1:0] wr_addr [N-1:0];
  logic [D_W-1:0]    wr_data [N-1:0];
  logic [N-1:0]      wr_en;

  mem_write_b #(.D_W(D_W), .N(N), .M(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_addr_bram (wr_addr),
    .wr_data_bram (wr_data),
    .wr_en_bram   (wr_en),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 idle, 1 loading, 2 done; k counts accepted elements
  int          m_phase = 0;
  int          m_k     = 0;
  bit          armed   = 1'b0;
  logic [N-1:0] e_en   = '0;
  int          e_addr [N];
  int          e_data [N];

  logic [D_W-1:0] mem  [N][DEPTH];
  logic [D_W-1:0] sent [TOTAL];
  int done_cnt = 0;
  int wr_cnt   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      armed   = 1'b1;
      m_phase = 0;
      m_k     = 0;
      e_en    = '0;
      for (int b = 0; b < N; b++) begin
        e_addr[b] = 0;
        e_data[b] = 0;
      end
    end else begin
      e_en = '0;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_k = 0; end
        1: if (in_valid) begin
             e_en[m_k % N]   = 1'b1;
             e_addr[m_k % N] = m_k / N;
             e_data[m_k % N] = int'(in_data);
             m_k++;
             if (m_k == TOTAL) m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
    #1;
    if (armed) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 1));
      chk("busy",     32'(busy),     32'(m_phase == 1));
      chk("done",     32'(done),     32'(m_phase == 2));
      for (int b = 0; b < N; b++) begin
        chk($sformatf("wr_en[%0d]", b),   32'(wr_en[b]),   32'(e_en[b]));
        chk($sformatf("wr_addr[%0d]", b), 32'(wr_addr[b]), 32'(e_addr[b]));
        chk($sformatf("wr_data[%0d]", b), 32'(wr_data[b]), 32'(e_data[b]));
        if (wr_en[b] === 1'b1) begin
          wr_cnt++;
          if (int'(wr_addr[b]) < DEPTH) mem[b][wr_addr[b]] = wr_data[b];
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_mem();
    for (int b = 0; b < N; b++)
      for (int a = 0; a < DEPTH; a++) mem[b][a] = 'x;
    for (int i = 0; i < TOTAL; i++) sent[i] = 'x;
  endtask

  task automatic check_mem(input string nm);
    for (int b = 0; b < N; b++)
      for (int a = 0; a < DEPTH; a++)
        chk($sformatf("%s mem[%0d][%0d]", nm, b, a), 32'(mem[b][a]), 32'(sent[a * N + b]));
  endtask

  // mode 0: valid held, 1: valid every other cycle, 2: random valid and data
  task automatic run_load(input int mode, input int base, input int restart_at,
                          input int abort_at);
    int cyc;
    @(negedge clk) start = 1'b1; in_valid = 1'b0;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (m_phase != 2 && cyc < 1000) begin
      if (abort_at >= 0 && m_k == abort_at) begin
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk) rst = 1'b0;
        return;
      end
      start    = (m_k == restart_at);
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : ($urandom_range(0, 3) != 0);
      in_data  = (mode == 2) ? D_W'($urandom) : D_W'(base + m_k);
      sent[m_k] = in_data;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (cyc >= 1000) chk("load_timeout", 32'(cyc), 32'(0));
    @(negedge clk);
  endtask

  initial begin
    int wr_before;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'(0));
    chk("rst_busy",  32'(busy),  32'(0));
    chk("rst_ready", 32'(in_ready), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Continuous stream 0..35
    clear_mem();
    run_load(0, 0, -1, -1);
    check_mem("held");
    chk("held_b0_a0",  32'(mem[0][0]),  32'(0));
    chk("held_b1_a4",  32'(mem[1][4]),  32'(13));
    chk("held_b2_a11", 32'(mem[2][11]), 32'(35));
    chk("held_done",   32'(done_cnt),   32'(1));

    // Idle with valid data must not write
    wr_before = wr_cnt;
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (4) @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'(0));
    chk("idle_nowr",  32'(wr_cnt),   32'(wr_before));
    in_valid = 1'b0;

    // Valid toggling every other cycle
    clear_mem();
    run_load(1, 0, -1, -1);
    check_mem("toggle");
    chk("toggle_done", 32'(done_cnt), 32'(2));

    // Valid after done: back in IDLE, ignored
    wr_before = wr_cnt;
    in_valid = 1'b1; in_data = 8'hAA;
    repeat (3) @(negedge clk);
    chk("post_done_nowr", 32'(wr_cnt), 32'(wr_before));
    chk("post_done_ready", 32'(in_ready), 32'(0));
    in_valid = 1'b0;

    // Abort after 17 transfers, then fresh random load
    clear_mem();
    run_load(0, 0, -1, 17);
    chk("abort_busy",  32'(busy),  32'(0));
    chk("abort_wr_en", 32'(wr_en), 32'(0));
    chk("abort_addr2", 32'(wr_addr[2]), 32'(0));
    chk("abort_done",  32'(done_cnt), 32'(2));
    clear_mem();
    run_load(2, 0, -1, -1);
    check_mem("random");
    chk("random_done", 32'(done_cnt), 32'(3));

    // start re-pulsed mid-load is ignored
    clear_mem();
    run_load(2, 0, -1, -1);
    clear_mem();
    run_load(0, 100, 5, -1);
    check_mem("restart");
    chk("restart_b2_a1", 32'(mem[2][1]), 32'(105));

    // Back-to-back loads, start in the cycle after done
    clear_mem();
    run_load(0, 50, -1, -1);
    run_load(1, 7, -1, -1);
    check_mem("b2b");
    chk("b2b_b0_a0", 32'(mem[0][0]), 32'(7));
    chk("b2b_done",  32'(done_cnt),  32'(7));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
